mod_sub: RTL

- Modular subtraction in Fp for the Ed448 field, p = 2^448 - 2^224 - 1. Computes diff = (a - b) mod p.
- Companion to the modular adder; the point add/double datapath uses it with the same start/done handshake.
- Limb-serial: one LIMB_WIDTH slice per cycle through a borrow chain, then a conditional limb-serial add-back of MODULUS.
- Chosen to keep the carry path short at 448 bits.

---
 rtl/mod_sub_pkg.sv | 27 ++
 rtl/mod_sub_if.sv | 30 +++
 rtl/mod_sub_limb_addsub.sv | 36 +++
 rtl/mod_sub.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mod_sub_pkg.sv
// -----------------------------------------------------------------------------
// mod_sub_pkg
// Shared constants and types for the Ed448 modular subtractor.
//   DATA_WIDTH  : field element width (448 bits)
//   MODULUS     : p = 2^448 - 2^224 - 1
//   LIMB_WIDTH  : bits processed per cycle by the limb-serial datapath
//   NUM_LIMBS   : DATA_WIDTH / LIMB_WIDTH, derived and never set directly
//   sub_state_t : control states of the subtractor
// -----------------------------------------------------------------------------
package mod_sub_pkg;

  localparam int DATA_WIDTH = 448;

  // p is all ones except bit 224, because 2^448 - 1 - 2^224 clears that bit.
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  localparam int LIMB_WIDTH = 64;
  localparam int NUM_LIMBS  = DATA_WIDTH / LIMB_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    FIX    = 2'd2,
    FINISH = 2'd3
  } sub_state_t;

endpackage

// File: rtl/mod_sub_if.sv
// -----------------------------------------------------------------------------
// mod_sub_if
// Request/response bundle of the modular subtractor.
//   start : one-cycle request pulse (requester -> subtractor)
//   a, b  : minuend / subtrahend, sampled with an accepted start
//   diff  : (a - b) mod p, valid while done is high
//   busy  : operation in flight
//   done  : level, high from completion until the next accepted start
// The requester uses the master modport, the subtractor the slave modport.
// -----------------------------------------------------------------------------
interface mod_sub_if import mod_sub_pkg::*; ();

  logic                  start;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] diff;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b,
    input  diff, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, busy, done
  );

endinterface

// File: rtl/mod_sub_limb_addsub.sv
// -----------------------------------------------------------------------------
// mod_sub_limb_addsub
// Combinational WIDTH-bit adder/subtractor with carry/borrow in and out.
//   x, y : operands
//   cin  : carry-in (add) or borrow-in (sub)
//   mode : 0 = add (x + y + cin), 1 = subtract (x - y - cin)
//   r    : WIDTH-bit wrapped result
//   cout : carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module mod_sub_limb_addsub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             mode,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  logic [WIDTH:0] sum;

  // Computing one bit wider makes the top bit the carry on add and, thanks to
  // two's-complement wrap, the borrow on subtract.
  always_comb begin
    if (mode) begin
      sum = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(cin);
    end else begin
      sum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin);
    end
  end

  assign r    = sum[WIDTH-1:0];
  assign cout = sum[WIDTH];

endmodule

// File: rtl/mod_sub.sv
// -----------------------------------------------------------------------------
// mod_sub
// Limb-serial modular subtraction in the Ed448 field: diff = (a - b) mod p.
// A borrow chain walks the limbs of W = a - b one limb per cycle; if the final
// borrow is set the result went negative and p is added back, again one limb
// per cycle, before the result is published.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mod_sub_if slave (start, a, b in; diff, busy, done out)
// Latency from the accepting edge to done: NUM_LIMBS+1 edges without the
// add-back pass, 2*NUM_LIMBS+1 edges with it.
// -----------------------------------------------------------------------------
module mod_sub import mod_sub_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  mod_sub_if.slave  bus
);

  localparam int IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  sub_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  cb_q, cb_d;      // borrow in SUB, carry in FIX
  logic [LIMB_WIDTH-1:0] w_q [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0] w_d [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0] b_q [NUM_LIMBS];
  logic [LIMB_WIDTH-1:0] b_d [NUM_LIMBS];
  logic [DATA_WIDTH-1:0] diff_q, diff_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LIMB_WIDTH-1:0] mod_limb [NUM_LIMBS];
  logic [DATA_WIDTH-1:0] w_flat;

  logic [LIMB_WIDTH-1:0] op_x, op_y, op_r;
  logic                  op_mode, op_cout;

  // Slice the modulus into limbs and reassemble the working register.
  generate
    for (genvar gi = 0; gi < NUM_LIMBS; gi++) begin : g_limb
      assign mod_limb[gi]                           = MODULUS[gi*LIMB_WIDTH +: LIMB_WIDTH];
      assign w_flat[gi*LIMB_WIDTH +: LIMB_WIDTH]    = w_q[gi];
    end
  endgenerate

  // One shared limb unit: subtract B during SUB, add MODULUS during FIX.
  assign op_mode = (state_q != FIX);
  assign op_x    = w_q[idx_q];
  assign op_y    = (state_q == FIX) ? mod_limb[idx_q] : b_q[idx_q];

  mod_sub_limb_addsub #(
    .WIDTH (LIMB_WIDTH)
  ) u_addsub (
    .x    (op_x),
    .y    (op_y),
    .cin  (cb_q),
    .mode (op_mode),
    .r    (op_r),
    .cout (op_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cb_d    = cb_q;
    w_d     = w_q;
    b_d     = b_q;
    diff_d  = diff_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < NUM_LIMBS; i++) begin
            w_d[i] = bus.a[i*LIMB_WIDTH +: LIMB_WIDTH];
            b_d[i] = bus.b[i*LIMB_WIDTH +: LIMB_WIDTH];
          end
          idx_d   = '0;
          cb_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = SUB;
        end
      end

      SUB: begin
        w_d[idx_q] = op_r;
        if (idx_q == LAST_IDX) begin
          // A final borrow means a < b: the wrapped value needs p added back.
          idx_d   = '0;
          cb_d    = 1'b0;
          state_d = op_cout ? FIX : FINISH;
        end else begin
          cb_d  = op_cout;
          idx_d = idx_q + 1'b1;
        end
      end

      FIX: begin
        w_d[idx_q] = op_r;
        if (idx_q == LAST_IDX) begin
          // The carry out of the top limb cancels the earlier wrap; drop it.
          idx_d   = '0;
          cb_d    = 1'b0;
          state_d = FINISH;
        end else begin
          cb_d  = op_cout;
          idx_d = idx_q + 1'b1;
        end
      end

      FINISH: begin
        diff_d  = w_flat;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cb_q    <= 1'b0;
      for (int i = 0; i < NUM_LIMBS; i++) begin
        w_q[i] <= '0;
        b_q[i] <= '0;
      end
      diff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cb_q    <= cb_d;
      w_q     <= w_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.diff = diff_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
